// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage in front of a combinational instruction ROM.
// Owns the PC, drives the ROM address and captures each {pc, instr} pair into
// a small FIFO. The FIFO head goes to decode through a valid/ready handshake.
// A redirect from execute reloads the PC and flushes every in-flight entry.
//
// Parameters:
//   RESET_PC  PC loaded on reset (4-byte aligned)
//   DEPTH     FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   imem_addr_o       ROM byte address (the PC register)
//   imem_instr_i      ROM read data for imem_addr_o (same cycle)
//   redirect_valid_i  redirect request; has priority over everything
//   redirect_pc_i     redirect target; bits [1:0] are dropped
//   instr_valid_o     FIFO head valid (forced low during a redirect cycle)
//   instr_ready_i     decode accepts the head
//   instr_o, pc_o     head instruction word and its address (0 when empty)
//   pc_plus4_o        pc_o + 4, modulo 2^32 (0 when empty)
//   fetch_misalign_o  sticky misaligned-redirect flag (IFETCH_MISALIGN_CHK_EN only)
// Build option: define IFETCH_MISALIGN_CHK_EN to stall fetch after a redirect
// to a misaligned target until a redirect to an aligned target arrives.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign_o
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty;
    logic               push;
    logic               pop;
    logic               fetch_blocked;
    fetch_entry_t       head_entry;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic               misalign_q, misalign_d;

    // Sticky flag: set by a misaligned redirect, cleared by an aligned one.
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid_i) begin
            misalign_d = |redirect_pc_i[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_blocked    = misalign_q;
    assign fetch_misalign_o = misalign_q;
`else
    assign fetch_blocked = 1'b0;
`endif

    assign empty       = (count_q == '0);
    assign head_entry  = mem_q[head_q];
    assign imem_addr_o = pc_q;

    // Head outputs; data reads zero when empty, valid is killed by a redirect.
    always_comb begin
        instr_valid_o = !empty && !redirect_valid_i;
        instr_o       = empty ? 32'h0 : head_entry.instr;
        pc_o          = empty ? 32'h0 : head_entry.pc;
        pc_plus4_o    = empty ? 32'h0 : head_entry.pc + 32'd4;
    end

    // Push is allowed at full when a pop frees the head slot in the same cycle.
    always_comb begin
        pop  = instr_valid_o && instr_ready_i;
        push = !redirect_valid_i && !fetch_blocked &&
               ((count_q < CNT_W'(DEPTH)) || pop);
    end

    // Next-state for PC, pointers, occupancy and storage.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (redirect_valid_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = '{pc: pc_q, instr: imem_instr_i};
                tail_d        = tail_q + PTR_W'(1);
                pc_d          = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a queue-based model of the fetch stage is
// stepped once per clock and compared with the DUT mid-cycle, plus literal
// spot checks at the interesting points of each scenario.
module tb_instruction_fetch;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        fetch_misalign_o;
`endif

    instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr_o      (imem_addr_o),
        .imem_instr_i     (imem_instr_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign_o (fetch_misalign_o)
`endif
    );

    always #5 clk = ~clk;

    // Combinational ROM: every address returns a distinct word.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    always_comb imem_instr_i = rom(imem_addr_o);

    // Model state: fetched-but-undelivered {pc, instr} pairs in order.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_flag;
    logic        m_known = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model for the inputs now applied.
    task automatic compare_model();
        logic        exp_valid;
        logic [63:0] hd;
        exp_valid = (m_q.size() != 0) && !redirect_valid_i;
        check("imem_addr", imem_addr_o, m_pc);
        check("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
        if (m_q.size() != 0) begin
            hd = m_q[0];
            if (exp_valid) begin
                check("pc_o", pc_o, hd[63:32]);
                check("instr_o", instr_o, hd[31:0]);
                check("pc_plus4_o", pc_plus4_o, hd[63:32] + 32'd4);
            end
        end else begin
            check("pc_o_empty", pc_o, 32'h0);
            check("instr_o_empty", instr_o, 32'h0);
            check("pc_plus4_o_empty", pc_plus4_o, 32'h0);
        end
`ifdef IFETCH_MISALIGN_CHK_EN
        check("fetch_misalign", 32'(fetch_misalign_o), 32'(m_flag));
`endif
    endtask

    // Advance the model across one rising edge using the held inputs.
    task automatic update_model();
        logic do_pop;
        logic do_push;
        if (!rst_n) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_flag  = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (redirect_valid_i) begin
                m_q.delete();
                m_pc = redirect_pc_i & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHK_EN
                m_flag = (redirect_pc_i[1:0] != 2'b00);
`endif
            end else begin
                do_pop  = (m_q.size() != 0) && instr_ready_i;
                do_push = !m_flag && ((m_q.size() < int'(DEPTH)) || do_pop);
                if (do_pop) void'(m_q.pop_front());
                if (do_push) begin
                    m_q.push_back({m_pc, rom(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // One clock: drive inputs, compare mid-cycle, then cross the edge.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst_n            = rst;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        instr_ready_i    = rdy;
        #2;
        if (m_known) compare_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'b1011_0010_1110_0101;

        // Reset, then streaming with ready held high.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_valid", 32'(instr_valid_o), 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        run(1, 1'b1);
        check("t1_valid", 32'(instr_valid_o), 32'h1);
        check("t1_pc0", pc_o, 32'h0);
        check("t1_addr4", imem_addr_o, 32'h4);
        run(1, 1'b1);
        check("t1_pc4", pc_o, 32'h4);
        run(1, 1'b1);
        check("t1_pc8", pc_o, 32'h8);
        check("t1_pc8_plus4", pc_plus4_o, 32'hC);
        check("t1_instr8", instr_o, 32'hDEAD_BEE7);

        // Back-pressure: FIFO fills, PC holds, then drains with no bubble.
        run(5, 1'b0);
        check("t2_hold_pc", pc_o, 32'h8);
        check("t2_hold_addr", imem_addr_o, 32'h10);
        run(1, 1'b1);
        check("t2_pcC", pc_o, 32'hC);
        run(1, 1'b1);
        check("t2_pc10", pc_o, 32'h10);

        // Redirect flushes in-flight entries; target appears two cycles later.
        step(1'b1, 1'b1, 32'h1C, 1'b1);
        check("t3_empty", 32'(instr_valid_o), 32'h0);
        check("t3_addr", imem_addr_o, 32'h1C);
        run(1, 1'b1);
        check("t3_pc1c", pc_o, 32'h1C);
        run(2, 1'b1);

        // Back-to-back redirects: the last one wins.
        step(1'b1, 1'b1, 32'h40, 1'b1);
        step(1'b1, 1'b1, 32'h80, 1'b1);
        run(1, 1'b1);
        check("b2b_pc", pc_o, 32'h80);
        run(2, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        run(1, 1'b1);
        check("t4_pc_top", pc_o, 32'hFFFF_FFFC);
        check("t4_plus4_wrap", pc_plus4_o, 32'h0);
        run(1, 1'b1);
        check("t4_pc_zero", pc_o, 32'h0);
        check("t4_addr", imem_addr_o, 32'h4);

        // Misaligned redirect target.
        step(1'b1, 1'b1, 32'h22, 1'b1);
        run(1, 1'b1);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("t5_flag", 32'(fetch_misalign_o), 32'h1);
        check("t5_stalled", 32'(instr_valid_o), 32'h0);
        check("t5_addr_hold", imem_addr_o, 32'h20);
`else
        check("t5_pc20", pc_o, 32'h20);
        check("t5_valid", 32'(instr_valid_o), 32'h1);
`endif
        run(3, 1'b1);
        step(1'b1, 1'b1, 32'h0, 1'b1);
        run(1, 1'b1);
        check("t5_recover_pc", pc_o, 32'h0);
        check("t5_recover_valid", 32'(instr_valid_o), 32'h1);

        // Irregular ready pattern.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'h0, pat[i]);

        // Redirect while full with decode ready: still no transfer.
        run(3, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b1);
        run(4, 1'b1);

        // Mid-stream reset with the FIFO full.
        run(3, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("t6_valid", 32'(instr_valid_o), 32'h0);
        check("t6_addr", imem_addr_o, RESET_PC);
        run(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
